// File: rtl/id_stage_pkg.sv
// Shared decode constants and instruction field-slice helpers for the ID stage.
package id_stage_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    function automatic logic [5:0] f_opcode(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [ADDR_W-1:0] f_rs(input logic [31:0] instr);
        return instr[25:21];
    endfunction

    function automatic logic [ADDR_W-1:0] f_rt(input logic [31:0] instr);
        return instr[20:16];
    endfunction

    function automatic logic [ADDR_W-1:0] f_rd(input logic [31:0] instr);
        return instr[15:11];
    endfunction

    function automatic logic [5:0] f_funct(input logic [31:0] instr);
        return instr[5:0];
    endfunction

    // Sign-extended immediate; zero-extension is left to EX.
    function automatic logic [DATA_W-1:0] f_imm(input logic [31:0] instr);
        return {{(DATA_W-16){instr[15]}}, instr[15:0]};
    endfunction

endpackage

// File: rtl/id_hazard_detect.sv
// Combinational load-use hazard compare between the load sitting in ID/EX
// and the source registers of the instruction currently in ID.
module id_hazard_detect
    import id_stage_pkg::*;
(
    input  logic              ex_valid,
    input  logic [5:0]        ex_opcode,
    input  logic [ADDR_W-1:0] ex_rt,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    output logic              hazard
);

    // A load targeting $0 never produces a usable value, so it never stalls.
    always_comb begin
        hazard = ex_valid && (ex_opcode == OP_LW) && (ex_rt != '0) &&
                 ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: register-file address drive, operand capture,
// immediate sign extension and the ID/EX pipeline register with load-use
// bubble, stall and flush handling.
// Optional build macro ID_WB_BYPASS_EN: forwards same-cycle writeback data
// into the captured operands.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int DATA_W = id_stage_pkg::DATA_W,
    parameter int ADDR_W = id_stage_pkg::ADDR_W,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [31:0]       if_instr,
    input  logic [PC_W-1:0]   if_pc,
    output logic [ADDR_W-1:0] readaddress1,
    output logic [ADDR_W-1:0] readaddress2,
    input  logic [DATA_W-1:0] readdata1,
    input  logic [DATA_W-1:0] readdata2,
    input  logic              wb_write,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rs_val,
    output logic [DATA_W-1:0] ex_rt_val,
    output logic [DATA_W-1:0] ex_imm,
    output logic [ADDR_W-1:0] ex_rs,
    output logic [ADDR_W-1:0] ex_rt,
    output logic [ADDR_W-1:0] ex_rd,
    output logic [5:0]        ex_opcode,
    output logic [5:0]        ex_funct,
    output logic [PC_W-1:0]   ex_pc
);

    logic              advance;
    logic              hazard;
    logic              take;
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

    // Field decode and register-file address drive straight from IF.
    always_comb begin
        id_rs        = f_rs(if_instr);
        id_rt        = f_rt(if_instr);
        readaddress1 = id_rs;
        readaddress2 = id_rt;
    end

    id_hazard_detect u_hazard (
        .ex_valid  (ex_valid),
        .ex_opcode (ex_opcode),
        .ex_rt     (ex_rt),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .hazard    (hazard)
    );

    // Handshake: flush wins over hazard and stall, so nothing is consumed then.
    always_comb begin
        advance  = ex_ready || !ex_valid;
        if_ready = advance && !hazard && !flush;
        take     = if_valid && if_ready;
    end

`ifdef ID_WB_BYPASS_EN
    // Writeback forwarding per operand; $0 is never forwarded.
    always_comb begin
        rs_val = readdata1;
        rt_val = readdata2;
        if (wb_write && (wb_addr != '0) && (wb_addr == id_rs)) rs_val = wb_data;
        if (wb_write && (wb_addr != '0) && (wb_addr == id_rt)) rt_val = wb_data;
    end
`else
    logic unused_wb;

    // Without forwarding the compiler spaces WB producers from ID consumers.
    always_comb begin
        rs_val    = readdata1;
        rt_val    = readdata2;
        unused_wb = ^{wb_write, wb_addr, wb_data};
    end
`endif

    // ID/EX register: flush or bubble clears everything, stall holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid  <= 1'b0;
            ex_rs_val <= '0;
            ex_rt_val <= '0;
            ex_imm    <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_rd     <= '0;
            ex_opcode <= '0;
            ex_funct  <= '0;
            ex_pc     <= '0;
        end else if (flush || (advance && !take)) begin
            ex_valid  <= 1'b0;
            ex_rs_val <= '0;
            ex_rt_val <= '0;
            ex_imm    <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_rd     <= '0;
            ex_opcode <= '0;
            ex_funct  <= '0;
            ex_pc     <= '0;
        end else if (take) begin
            ex_valid  <= 1'b1;
            ex_rs_val <= rs_val;
            ex_rt_val <= rt_val;
            ex_imm    <= f_imm(if_instr);
            ex_rs     <= id_rs;
            ex_rt     <= id_rt;
            ex_rd     <= f_rd(if_instr);
            ex_opcode <= f_opcode(if_instr);
            ex_funct  <= f_funct(if_instr);
            ex_pc     <= if_pc;
        end
    end

endmodule
